// File: rtl/hash160_range_match_if.sv
// Bundle of digest input, range bounds, match FIFO head and status signals
// shared between hash160_range_match and the logic that drives it.
interface hash160_range_match_if;
    logic         rx_done;
    logic [159:0] rx_hash;
    logic [31:0]  rx_id;
    logic [159:0] rx_min;
    logic [159:0] rx_max;
    logic         rx_match_ack;
    logic         tx_match_valid;
    logic [159:0] tx_match_hash;
    logic [31:0]  tx_match_id;
    logic         tx_busy;
    logic         tx_overflow;
    logic [31:0]  tx_checked;
    logic [31:0]  tx_dropped;

    modport master (
        output rx_done, rx_hash, rx_id, rx_min, rx_max, rx_match_ack,
        input  tx_match_valid, tx_match_hash, tx_match_id, tx_busy,
               tx_overflow, tx_checked, tx_dropped
    );

    modport slave (
        input  rx_done, rx_hash, rx_id, rx_min, rx_max, rx_match_ack,
        output tx_match_valid, tx_match_hash, tx_match_id, tx_busy,
               tx_overflow, tx_checked, tx_dropped
    );
endinterface

// File: rtl/hash160_range_match.sv
// Compares each new RIPEMD-160 digest against an inclusive [min,max] window and queues hits.
// Define HASH160_RANGE_MATCH_STATS_EN to build the checked/dropped counters.
module hash160_range_match #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rx_reset_n,
    hash160_range_match_if.slave  bus
);
    // state  | meaning
    // IDLE   | waiting for a rise of rx_done
    // CMP_LO | registering hash >= rx_min
    // CMP_HI | registering hash <= rx_max
    // PUSH   | writing a hit into the FIFO
    typedef enum logic [1:0] {IDLE, CMP_LO, CMP_HI, PUSH} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t         state_q, state_d;
    logic           done_q, done_d, done2_q, done2_d;
    logic [159:0]   hash_q, hash_d;
    logic [31:0]    id_q, id_d;
    logic           ge_q, ge_d, le_q, le_d;
    logic           overflow_q, overflow_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [191:0]   mem_q [DEPTH];
    logic           rise, push, pop, full;
    logic [191:0]   head;

    // rise is seen one cycle after rx_done is first sampled high
    assign rise = done_q & ~done2_q;
    assign full = (count_q == FULL_CNT);
    assign pop  = (count_q != '0) & bus.rx_match_ack;

    always_comb begin
        state_d    = state_q;
        done_d     = bus.rx_done;
        done2_d    = done_q;
        hash_d     = hash_q;
        id_d       = id_q;
        ge_d       = ge_q;
        le_d       = le_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    hash_d  = bus.rx_hash;
                    id_d    = bus.rx_id;
                    state_d = CMP_LO;
                end
            end
            CMP_LO: begin
                ge_d    = (hash_q >= bus.rx_min);
                state_d = CMP_HI;
            end
            CMP_HI: begin
                le_d    = (hash_q <= bus.rx_max);
                state_d = PUSH;
            end
            PUSH: begin
                // a pop on the same edge frees the slot even when full
                if (ge_q && le_q) begin
                    if (!full || pop) push = 1'b1;
                    else              overflow_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            done2_q    <= 1'b0;
            hash_q     <= '0;
            id_q       <= '0;
            ge_q       <= 1'b0;
            le_q       <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            done2_q    <= done2_d;
            hash_q     <= hash_d;
            id_q       <= id_d;
            ge_q       <= ge_d;
            le_q       <= le_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {hash_q, id_q};
    end

    // head is gated so the outputs read zero whenever the FIFO is empty or in reset
    assign head               = mem_q[rd_ptr_q];
    assign bus.tx_match_valid = (count_q != '0);
    assign bus.tx_match_hash  = bus.tx_match_valid ? head[191:32] : '0;
    assign bus.tx_match_id    = bus.tx_match_valid ? head[31:0]   : '0;
    assign bus.tx_busy        = (state_q != IDLE);
    assign bus.tx_overflow    = overflow_q;

`ifdef HASH160_RANGE_MATCH_STATS_EN
    logic [31:0] checked_q, checked_d, dropped_q, dropped_d;

    always_comb begin
        checked_d = checked_q;
        dropped_d = dropped_q;
        if (rise) begin
            if (state_q == IDLE) checked_d = checked_q + 32'd1;
            else                 dropped_d = dropped_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            checked_q <= '0;
            dropped_q <= '0;
        end else begin
            checked_q <= checked_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.tx_checked = checked_q;
    assign bus.tx_dropped = dropped_q;
`else
    assign bus.tx_checked = '0;
    assign bus.tx_dropped = '0;
`endif
endmodule

// File: doc/hash160_range_match.md
HASH160_RANGE_MATCH -- requirements
Module: hash160_range_match

Interface
REQ-001 Parameter DEPTH, default 4, match-FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rx_reset_n  in  1  reset, asynchronous and active-low.
REQ-004 rx_done  in  1  digest-ready level from the upstream RIPEMD-160 stage; stays high until that stage restarts.
REQ-005 rx_hash  in  160  RIPEMD-160 digest; bits [159:152] are digest byte 0.
REQ-006 rx_id  in  32  candidate index of the digest, valid while rx_done is high.
REQ-007 rx_min  in  160  inclusive lower bound; quasi-static.
REQ-008 rx_max  in  160  inclusive upper bound; quasi-static.
REQ-009 tx_match_valid  out  1  FIFO head valid.
REQ-010 tx_match_hash  out  160  head digest.
REQ-011 tx_match_id  out  32  head candidate index.
REQ-012 rx_match_ack  in  1  pops the head when sampled high together with tx_match_valid.
REQ-013 tx_busy  out  1  high while a digest is being compared.
REQ-014 tx_overflow  out  1  sticky; a match was dropped because the FIFO was full.
REQ-015 tx_checked  out  32  digests accepted for comparison.
REQ-016 tx_dropped  out  32  rx_done rises ignored because the block was busy.

Function
REQ-017 A new digest SHALL be detected only on a 0->1 transition of rx_done, using a registered copy of rx_done.
REQ-018 The FSM SHALL have states IDLE, CMP_LO, CMP_HI and PUSH.
REQ-019 In IDLE, on a detected rise, the block SHALL capture rx_hash and rx_id, set tx_busy, and go to CMP_LO.
REQ-020 CMP_LO SHALL register (hash >= rx_min) as unsigned 160-bit and go to CMP_HI.
REQ-021 CMP_HI SHALL register (hash <= rx_max) as unsigned 160-bit and go to PUSH.
REQ-022 PUSH SHALL write {hash,id} to the FIFO if both flags are set and the FIFO is not full, then return to IDLE and clear tx_busy.
REQ-023 tx_match_valid SHALL rise 4 cycles after the cycle in which the rise was first sampled, when the FIFO was empty.
REQ-024 A rise detected outside IDLE SHALL be discarded and SHALL increment tx_dropped.
REQ-025 tx_checked SHALL increment on each entry to CMP_LO.
REQ-026 A match in PUSH with the FIFO full SHALL be discarded and SHALL set tx_overflow, which stays set until reset.
REQ-027 A simultaneous push and pop SHALL be allowed in all occupancy states, including full (net occupancy unchanged).
REQ-028 FIFO pointers SHALL wrap modulo DEPTH.
REQ-029 When rx_min > rx_max, no digest SHALL match.
REQ-030 Counters SHALL wrap from 32'hFFFFFFFF to 0.
REQ-031 tx_match_hash and tx_match_id SHALL be don't-care while tx_match_valid is low.

Reset
REQ-032 rx_reset_n low SHALL immediately force the FSM to IDLE, empty the FIFO, and clear the registered rx_done copy.
REQ-033 rx_reset_n low SHALL immediately clear tx_match_valid, tx_busy, tx_overflow, tx_checked, tx_dropped, tx_match_hash and tx_match_id.
REQ-034 Reset mid-comparison SHALL abandon the digest with no FIFO write.
REQ-035 An rx_done already high at reset release SHALL count as a rise on the first clock after release.

Configuration
REQ-036 With HASH160_RANGE_MATCH_STATS_EN defined, tx_checked and tx_dropped SHALL be implemented as specified.
REQ-037 Without HASH160_RANGE_MATCH_STATS_EN, tx_checked and tx_dropped SHALL be constant 0 with no counter registers; all other behaviour SHALL be unchanged.

Verification
REQ-038 min=0, max=all-ones; one rx_done rise with id=7 -> tx_match_valid high 4 cycles later with id=7; ack -> valid low next cycle; tx_checked=1.
REQ-039 min=max=H; digests H-1, H, H+1 -> exactly one FIFO entry, hash=H; tx_checked=3.
REQ-040 DEPTH=4, full range, no ack, 5 digests -> 4 entries, tx_overflow=1; then 4 acks return ids in arrival order.
REQ-041 rx_done pulsed 0->1 twice, 2 cycles apart -> second rise ignored; tx_dropped=1, tx_checked=1.
REQ-042 rx_reset_n low during CMP_HI of a matching digest -> all outputs 0, no entry after release.
REQ-043 min > max; 10 digests -> tx_match_valid never asserts; tx_checked=10 with STATS_EN, 0 without.
